braid_dose_sequencer: RTL and testbench

BRAID_DOSE_SEQUENCER -- requirements
Module: braid_dose_sequencer

---
 rtl/braid_seq_pkg.sv | 29 ++
 rtl/dose_fifo.sv | 63 ++++++
 rtl/braid_dose_sequencer.sv | 136 +++++++++++++
 tb/tb_braid_dose_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/braid_seq_pkg.sv
// rtl/braid_seq_pkg.sv - shared types and constants for the braid dose sequencer
package braid_seq_pkg;

  localparam int NUM_CHAN   = 3;
  localparam int DOSE_CNT_W = 16;

  typedef logic [1:0] chan_t;

  localparam chan_t CHAN_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPEN   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  // One-hot valve drive for a channel; the illegal code maps to all-closed.
  function automatic logic [NUM_CHAN-1:0] chan_onehot(input chan_t chan);
    logic [NUM_CHAN-1:0] v;
    case (chan)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      2'd2:    v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dose_fifo.sv
// rtl/dose_fifo.sv - synchronous request FIFO with full/empty and synchronous flush
module dose_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next-state: flush wins over push/pop; push into a full queue is dropped.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = wdata;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // State registers with asynchronous reset to the empty queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/braid_dose_sequencer.sv
// rtl/braid_dose_sequencer.sv - queued per-channel valve dosing with settle time and counters
module braid_dose_sequencer
  import braid_seq_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int VOL_W         = 8,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_chan,
  input  logic [VOL_W-1:0] req_vol,
  input  logic             abort,
  output logic [2:0]       valve_open,
  output logic             busy,
  output logic             done,
  output logic             err_chan,
  output logic [47:0]      dose_cnt
);

  localparam int              SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);
  localparam logic [VOL_W-1:0] VOL_ONE    = VOL_W'(1);

  state_e                                state_q, state_d;
  chan_t                                 chan_q, chan_d;
  logic [VOL_W-1:0]                      vol_cnt_q, vol_cnt_d;
  logic [SW-1:0]                         settle_cnt_q, settle_cnt_d;
  logic                                  err_q, err_d;
  logic [NUM_CHAN-1:0][DOSE_CNT_W-1:0]   dose_cnt_q, dose_cnt_d;

  logic             fifo_full, fifo_empty;
  logic [VOL_W+1:0] fifo_rdata;
  logic             accept, push, pop, settle_last;
  chan_t            head_chan;
  logic [VOL_W-1:0] head_vol;

  assign head_chan   = fifo_rdata[VOL_W+1:VOL_W];
  assign head_vol    = fifo_rdata[VOL_W-1:0];
  assign req_ready   = !fifo_full;
  assign accept      = req_valid && req_ready && !abort;
  assign push        = accept && (req_chan != CHAN_ILLEGAL);
  assign pop         = (state_q == ST_IDLE) && !fifo_empty && !abort;
  assign settle_last = (state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_LAST);

  dose_fifo #(
    .WIDTH (VOL_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_chan, req_vol}),
    .pop   (pop),
    .flush (abort),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs decode registered state directly so reset closes valves without a clock.
  assign valve_open = (state_q == ST_OPEN) ? chan_onehot(chan_q) : 3'b000;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty;
  assign done       = settle_last && !abort;
  assign err_chan   = err_q;
  assign dose_cnt   = dose_cnt_q;

  // Dose FSM: pop in IDLE, hold valve for vol cycles, then settle and count.
  always_comb begin
    state_d      = state_q;
    chan_d       = chan_q;
    vol_cnt_d    = vol_cnt_q;
    settle_cnt_d = settle_cnt_q;
    err_d        = err_q;
    dose_cnt_d   = dose_cnt_q;
    if (accept && (req_chan == CHAN_ILLEGAL)) err_d = 1'b1;
    if (abort) begin
      state_d      = ST_IDLE;
      vol_cnt_d    = '0;
      settle_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            chan_d       = head_chan;
            vol_cnt_d    = head_vol;
            settle_cnt_d = '0;
            state_d      = (head_vol != '0) ? ST_OPEN : ST_SETTLE;
          end
        end
        ST_OPEN: begin
          if (vol_cnt_q == VOL_ONE) begin
            state_d      = ST_SETTLE;
            settle_cnt_d = '0;
          end else begin
            vol_cnt_d = vol_cnt_q - VOL_ONE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_d = ST_IDLE;
            for (int c = 0; c < NUM_CHAN; c++) begin
              if (chan_q == chan_t'(c)) dose_cnt_d[c] = dose_cnt_q[c] + 16'd1;
            end
          end else begin
            settle_cnt_d = settle_cnt_q + SETTLE_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      chan_q       <= '0;
      vol_cnt_q    <= '0;
      settle_cnt_q <= '0;
      err_q        <= 1'b0;
      dose_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      vol_cnt_q    <= vol_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      err_q        <= err_d;
      dose_cnt_q   <= dose_cnt_d;
    end
  end

endmodule

// File: tb/tb_braid_dose_sequencer.sv
// tb/tb_braid_dose_sequencer.sv - self-checking bench for braid_dose_sequencer
module tb_braid_dose_sequencer;

  localparam int FIFO_DEPTH = 4;
  localparam int VOL_W      = 8;
  localparam int SETTLE     = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_chan;
  logic [VOL_W-1:0] req_vol;
  logic             abort;
  logic [2:0]       valve_open;
  logic             busy;
  logic             done;
  logic             err_chan;
  logic [47:0]      dose_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  braid_dose_sequencer #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .VOL_W         (VOL_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_chan   (req_chan),
    .req_vol    (req_vol),
    .abort      (abort),
    .valve_open (valve_open),
    .busy       (busy),
    .done       (done),
    .err_chan   (err_chan),
    .dose_cnt   (dose_cnt)
  );

  typedef struct {
    logic [1:0] chan;
    logic [7:0] vol;
    logic [2:0] exp_valve;
    int         exp_open;
    int         exp_first;
    int         exp_done;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [1:0] chan;
    int         vol;
  } req_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    req_chan  = 2'd0;
    req_vol   = '0;
    abort     = 1'b0;
  endtask

  task automatic drive_req(input logic [1:0] c, input logic [7:0] v);
    req_valid = 1'b1;
    req_chan  = c;
    req_vol   = v;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    next();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_valve"}, 64'(valve_open), 64'd0);
    chk({tag, "_done"},  64'(done), 64'd0);
    chk({tag, "_busy"},  64'(busy), 64'd0);
    chk({tag, "_err"},   64'(err_chan), 64'd0);
    chk({tag, "_cnt"},   64'(dose_cnt), 64'd0);
    chk({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int          first, opens, done_at, gap, ndone, nrun, last_done, k;
    logic [2:0]  pat, prev_valve;
    logic [2:0]  order [4];
    logic [47:0] cnt0;
    bit          busy_seen, multi_hot, seen_ready;
    // reference model state
    req_t        mq[$];
    req_t        r;
    bit          act, m_err, m_accept, m_ready;
    int          a_chan, a_vol, a_t0, t, e;
    int          m_cnt[3];
    logic [2:0]  exp_valve;
    logic        exp_done;

    vecs[0] = '{2'd1, 8'd5,   3'b010, 5,   2,  14,  1'b0};
    vecs[1] = '{2'd2, 8'd0,   3'b000, 0,   -1, 9,   1'b0};
    vecs[2] = '{2'd0, 8'd1,   3'b001, 1,   2,  10,  1'b0};
    vecs[3] = '{2'd0, 8'd3,   3'b001, 3,   2,  12,  1'b0};
    vecs[4] = '{2'd2, 8'd200, 3'b100, 200, 2,  209, 1'b0};
    vecs[5] = '{2'd3, 8'd7,   3'b000, 0,   -1, -1,  1'b1};

    do_reset();
    chk_reset_values("reset");

    // Single-dose table: latency, pulse width, done timing and counters.
    for (int i = 0; i < 6; i++) begin
      cnt0 = dose_cnt;
      next();
      drive_req(vecs[i].chan, vecs[i].vol);
      next();
      idle_inputs();
      first = -1; opens = 0; done_at = -1; pat = '0; busy_seen = 0; multi_hot = 0;
      for (k = 1; k <= 300; k++) begin
        if (valve_open != 3'b000) begin
          opens++;
          pat |= valve_open;
          if (first < 0) first = k;
        end
        if ($countones(valve_open) > 1) multi_hot = 1;
        if (done) done_at = k;
        busy_seen |= busy;
        if (done_at >= 0 || (vecs[i].exp_done < 0 && k >= 20)) break;
        next();
      end
      next();
      chk("vec_pattern", 64'(pat), 64'(vecs[i].exp_valve));
      chk("vec_open_cycles", 64'(opens), 64'(vecs[i].exp_open));
      chk("vec_first_open", 64'(first), 64'(vecs[i].exp_first));
      chk("vec_done_cycle", 64'(done_at), 64'(vecs[i].exp_done));
      chk("vec_one_hot", 64'(multi_hot), 64'd0);
      chk("vec_err", 64'(err_chan), 64'(vecs[i].exp_err));
      chk("vec_busy_seen", 64'(busy_seen), 64'(vecs[i].exp_done >= 0));
      chk("vec_busy_end", 64'(busy), 64'd0);
      chk("vec_cnt", 64'(dose_cnt),
          64'(cnt0 + ((vecs[i].exp_done >= 0) ? (48'd1 << (16 * vecs[i].chan)) : 48'd0)));
    end

    // Four back-to-back doses: FIFO order and exactly one IDLE cycle between doses.
    next(); drive_req(2'd0, 8'd3);
    next(); drive_req(2'd2, 8'd2);
    next(); drive_req(2'd1, 8'd1);
    next(); drive_req(2'd0, 8'd4);
    next(); idle_inputs();
    ndone = 0; nrun = 0; last_done = -100; prev_valve = '0;
    for (k = 0; k < 200 && ndone < 4; k++) begin
      if (valve_open != 3'b000 && prev_valve == 3'b000) begin
        if (nrun < 4) order[nrun] = valve_open;
        if (nrun > 0) chk("b2b_gap", 64'(k - last_done), 64'd2);
        nrun++;
      end
      if (done) begin ndone++; last_done = k; end
      prev_valve = valve_open;
      next();
    end
    chk("b2b_ndone", 64'(ndone), 64'd4);
    chk("b2b_nrun", 64'(nrun), 64'd4);
    chk("b2b_order0", 64'(order[0]), 64'(3'b001));
    chk("b2b_order1", 64'(order[1]), 64'(3'b100));
    chk("b2b_order2", 64'(order[2]), 64'(3'b010));
    chk("b2b_order3", 64'(order[3]), 64'(3'b001));

    // Queue full while a long dose runs: ready held low, nothing lost.
    next(); cnt0 = dose_cnt;
    drive_req(2'd1, 8'd30);
    next(); drive_req(2'd0, 8'd1);
    next(); drive_req(2'd2, 8'd1);
    next(); drive_req(2'd0, 8'd2);
    next(); drive_req(2'd1, 8'd0);
    next(); drive_req(2'd2, 8'd1);
    chk("full_ready_low", 64'(req_ready), 64'd0);
    ndone = 0; last_done = -100; seen_ready = 0;
    for (k = 0; k < 100; k++) begin
      if (req_ready) begin seen_ready = 1; break; end
      if (done) begin ndone++; last_done = k; end
      next();
    end
    chk("full_ready_back", 64'(seen_ready), 64'd1);
    chk("full_done_before_ready", 64'(ndone), 64'd1);
    chk("full_ready_delay", 64'(k - last_done), 64'd2);
    next(); idle_inputs();
    ndone = 0;
    for (k = 0; k < 200 && ndone < 5; k++) begin
      if (done) ndone++;
      next();
    end
    next();
    chk("full_drain_ndone", 64'(ndone), 64'd5);
    chk("full_drain_cnt", 64'(dose_cnt), 64'(cnt0 + {16'd2, 16'd2, 16'd2}));

    // Abort in the third OPEN cycle with two doses queued.
    cnt0 = dose_cnt;
    next(); drive_req(2'd0, 8'd10);
    next(); drive_req(2'd1, 8'd2);
    next(); drive_req(2'd2, 8'd3);
    next(); idle_inputs();
    next();
    chk("abort_valve_before", 64'(valve_open), 64'(3'b001));
    abort = 1'b1;
    #1;
    chk("abort_done_gate", 64'(done), 64'd0);
    next();
    abort = 1'b0;
    chk("abort_valve_after", 64'(valve_open), 64'd0);
    chk("abort_busy_after", 64'(busy), 64'd0);
    pat = '0; ndone = 0;
    for (k = 0; k < 40; k++) begin
      pat |= valve_open;
      if (done) ndone++;
      next();
    end
    chk("abort_no_valve", 64'(pat), 64'd0);
    chk("abort_no_done", 64'(ndone), 64'd0);
    chk("abort_cnt", 64'(dose_cnt), 64'(cnt0));

    // Reset asserted between edges while a valve is open.
    next(); drive_req(2'd1, 8'd20);
    next(); idle_inputs();
    next();
    next();
    chk("rst_valve_before", 64'(valve_open), 64'(3'b010));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values("rst_async");
    @(negedge clk);
    rst = 1'b0;
    next();
    chk("rst_post_valve", 64'(valve_open), 64'd0);
    chk("rst_post_busy", 64'(busy), 64'd0);

    // Randomized traffic against a timeline-based reference model.
    do_reset();
    act = 0; m_err = 0; t = 0; a_chan = 0; a_vol = 0; a_t0 = 0;
    for (int c = 0; c < 3; c++) m_cnt[c] = 0;
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next();
      req_valid = ($urandom_range(0, 1) == 1);
      req_chan  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req_vol   = 8'($urandom_range(0, 12));
      abort     = ($urandom_range(0, 59) == 0);
      #1;
      e         = t - a_t0 - 1;
      exp_valve = (act && e < a_vol) ? 3'(1 << a_chan) : 3'b000;
      exp_done  = act && (e == a_vol + SETTLE - 1) && !abort;
      m_ready   = (mq.size() < FIFO_DEPTH);
      chk("rnd_valve", 64'(valve_open), 64'(exp_valve));
      chk("rnd_done", 64'(done), 64'(exp_done));
      chk("rnd_busy", 64'(busy), 64'(act || mq.size() > 0));
      chk("rnd_ready", 64'(req_ready), 64'(m_ready));
      chk("rnd_err", 64'(err_chan), 64'(m_err));
      chk("rnd_cnt", 64'(dose_cnt),
          64'({m_cnt[2][15:0], m_cnt[1][15:0], m_cnt[0][15:0]}));
      m_accept = req_valid && m_ready && !abort;
      if (abort) begin
        mq.delete();
        act = 0;
      end else begin
        if (act && e == a_vol + SETTLE - 1) begin
          act = 0;
          m_cnt[a_chan] = (m_cnt[a_chan] + 1) & 16'hFFFF;
        end else if (!act && mq.size() > 0) begin
          r = mq.pop_front();
          act = 1; a_chan = int'(r.chan); a_vol = r.vol; a_t0 = t;
        end
        if (m_accept) begin
          if (req_chan == 2'd3) m_err = 1;
          else mq.push_back('{req_chan, int'(req_vol)});
        end
      end
      t++;
    end
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
